// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts a one-cycle bubble on a load-use dependency, squashes on flush, and
// counts inserted load-use bubbles (saturating).
// Optional feature macro: MULDIV_STALL_EN -- when defined, a mult/div entering
// EX freezes ID/EX and the front end for MULDIV_LAT-1 further cycles.
module idex_hazard_reg #(
  parameter int DW         = 32,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_rd,
  input  logic [DW-1:0]    id_rd1,
  input  logic [DW-1:0]    id_rd2,
  input  logic [DW-1:0]    id_imm,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_alusrc,
  input  logic [3:0]       id_aluop,
  input  logic             id_is_muldiv,
  input  logic             flush,
  output logic             stall_if_id,
  output logic             ex_valid,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [DW-1:0]    ex_rd1,
  output logic [DW-1:0]    ex_rd2,
  output logic [DW-1:0]    ex_imm,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_alusrc,
  output logic [3:0]       ex_aluop,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] bubble_cnt
);

  // One bundle for everything that travels from ID into EX; a bubble is all zeros.
  typedef struct packed {
    logic          valid;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic          alusrc;
    logic [3:0]    aluop;
  } idex_t;

  idex_t            id_pkt;
  idex_t            ex_q, ex_d;
  logic [CNT_W-1:0] bub_q, bub_d;
  logic             freeze;
  logic             load_use;

  // Gather the decode-stage fields into one bundle.
  always_comb begin
    id_pkt          = '0;
    id_pkt.valid    = id_valid;
    id_pkt.rs       = id_rs;
    id_pkt.rt       = id_rt;
    id_pkt.rd       = id_rd;
    id_pkt.rd1      = id_rd1;
    id_pkt.rd2      = id_rd2;
    id_pkt.imm      = id_imm;
    id_pkt.regwrite = id_regwrite;
    id_pkt.memread  = id_memread;
    id_pkt.memwrite = id_memwrite;
    id_pkt.memtoreg = id_memtoreg;
    id_pkt.alusrc   = id_alusrc;
    id_pkt.aluop    = id_aluop;
  end

`ifdef MULDIV_STALL_EN
  // Remaining frozen cycles of the mult/div now in EX; LAT-1 fits in clog2(LAT) bits.
  localparam int MC_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
  logic [MC_W-1:0] mcnt_q, mcnt_d;
  assign freeze = (mcnt_q != '0);
`else
  // Without the freeze feature the mult/div flag and latency have no effect.
  logic unused_muldiv;
  assign unused_muldiv = id_is_muldiv | (MULDIV_LAT < 2);
  assign freeze = 1'b0;
`endif

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & id_valid &
               ((ex_q.rd == id_rs) | (id_uses_rt & (ex_q.rd == id_rt)));
  end

  // Front-end hold: freeze always wins; a flush cancels the load-use hold.
  assign stall_if_id = freeze | (load_use & ~flush);

  // Next state with priority freeze > flush > load-use > advance.
  always_comb begin
    ex_d  = ex_q;
    bub_d = bub_q;
`ifdef MULDIV_STALL_EN
    mcnt_d = mcnt_q;
`endif
    if (freeze) begin
`ifdef MULDIV_STALL_EN
      mcnt_d = mcnt_q - MC_W'(1);
`endif
    end else if (flush) begin
      ex_d = '0;
    end else if (load_use) begin
      ex_d = '0;
      if (bub_q != '1) begin
        bub_d = bub_q + CNT_W'(1);
      end
    end else begin
      ex_d = id_pkt;
`ifdef MULDIV_STALL_EN
      if (id_valid && id_is_muldiv) begin
        mcnt_d = MC_W'(MULDIV_LAT - 1);
      end
`endif
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      bub_q  <= '0;
`ifdef MULDIV_STALL_EN
      mcnt_q <= '0;
`endif
    end else begin
      ex_q   <= ex_d;
      bub_q  <= bub_d;
`ifdef MULDIV_STALL_EN
      mcnt_q <= mcnt_d;
`endif
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign ex_rd       = ex_q.rd;
  assign ex_rd1      = ex_q.rd1;
  assign ex_rd2      = ex_q.rd2;
  assign ex_imm      = ex_q.imm;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memtoreg = ex_q.memtoreg;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_aluop    = ex_q.aluop;
  assign muldiv_busy = freeze;
  assign bubble_cnt  = bub_q;

endmodule
